activation: RTL and testbench

ACTIVATION -- requirements
Module: activation

---
 rtl/activation.sv | 199 +++++++++++++++++++
 tb/tb_activation.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation.sv
// Per-lane activation pipeline (Identity / Relu / integer GELU with requantisation), 4 stages.
// Define ACTIVATION_ASSERT_EN to enable simulation assertions on the inputs and on data_o.

package ita_package;
   parameter int unsigned N_PE = 16;

   typedef logic [N_PE-1:0][7:0] requant_oup_t;
   typedef logic signed [15:0]   gelu_const_t;
   typedef logic [7:0]           requant_const_t;
   typedef logic signed [7:0]    requant_t;

   typedef enum logic [1:0] {
      Identity = 2'd0,
      Gelu     = 2'd1,
      Relu     = 2'd2
   } activation_e;

   typedef enum logic {
      Signed   = 1'b0,
      Unsigned = 1'b1
   } requant_mode_e;
endpackage

module activation
   import ita_package::*;
(
   input  logic           clk_i,
   input  logic           rst_ni,
   input  gelu_const_t    one_i,
   input  gelu_const_t    b_i,
   input  gelu_const_t    c_i,
   input  requant_oup_t   data_i,
   input  activation_e    activation_i,
   input  requant_mode_e  requant_mode_i,
   input  requant_const_t requant_mult_i,
   input  requant_const_t requant_shift_i,
   input  requant_t       requant_add_i,
   input  logic           calc_en_q_i,
   output requant_oup_t   data_o
);

   // L = sign(x) * ((min(|x|, -b) + b)^2 + c)
   function automatic logic signed [31:0] gelu_poly(input logic signed [7:0] x,
                                                    input gelu_const_t b,
                                                    input gelu_const_t c);
      logic signed [31:0] xs, absx, bs, negb, a, t, poly;
      xs   = {{24{x[7]}}, x};
      absx = x[7] ? -xs : xs;
      bs   = {{16{b[15]}}, b};
      negb = -bs;
      a    = (absx < negb) ? absx : negb;
      t    = a + bs;
      poly = t * t + {{16{c[15]}}, c};
      return x[7] ? -poly : poly;
   endfunction

   function automatic logic signed [31:0] gelu_mult(input logic signed [7:0] x,
                                                    input logic signed [31:0] l,
                                                    input gelu_const_t one);
      logic signed [31:0] xs, os;
      xs = {{24{x[7]}}, x};
      os = {{16{one[15]}}, one};
      return xs * (l + os);
   endfunction

   // Round-half-up arithmetic shift, offset, then clamp to the selected 8-bit range.
   function automatic logic [7:0] requant(input logic signed [31:0] g,
                                          input requant_const_t mult,
                                          input requant_const_t shift,
                                          input requant_t add,
                                          input requant_mode_e mode);
      logic signed [47:0] p, r, v;
      logic [7:0] res;
      p = $signed({{16{g[31]}}, g}) * $signed({40'd0, mult});
      if (shift == 8'd0) r = p;
      else r = (p + (48'sd1 <<< (shift - 8'd1))) >>> shift;
      v = r + $signed({{40{add[7]}}, add});
      if (mode == Unsigned) begin
         if (v < 48'sd0) res = 8'h00;
         else if (v > 48'sd255) res = 8'hff;
         else res = v[7:0];
      end else begin
         if (v < -48'sd128) res = 8'h80;
         else if (v > 48'sd127) res = 8'h7f;
         else res = v[7:0];
      end
      return res;
   endfunction

   // Stage 1: sampled beat and the constants that travel with it
   requant_oup_t   x1_q;
   activation_e    act1_q;
   gelu_const_t    one1_q, b1_q, c1_q;
   requant_mode_e  mode1_q;
   requant_const_t mult1_q, shift1_q;
   requant_t       add1_q;

   // Stage 2
   requant_oup_t            x2_q;
   activation_e             act2_q;
   logic [N_PE-1:0][31:0]   l2_q, l2_d;
   gelu_const_t             one2_q;
   requant_mode_e           mode2_q;
   requant_const_t          mult2_q, shift2_q;
   requant_t                add2_q;

   // Stage 3
   requant_oup_t            x3_q;
   activation_e             act3_q;
   logic [N_PE-1:0][31:0]   g3_q, g3_d;
   requant_mode_e           mode3_q;
   requant_const_t          mult3_q, shift3_q;
   requant_t                add3_q;

   requant_oup_t out_d;

   always_comb begin
      l2_d = '0;
      g3_d = '0;
      out_d = '0;
      for (int i = 0; i < int'(N_PE); i++) begin
         l2_d[i] = gelu_poly($signed(x1_q[i]), b1_q, c1_q);
         g3_d[i] = gelu_mult($signed(x2_q[i]), $signed(l2_q[i]), one2_q);
         case (act3_q)
            Relu:    out_d[i] = ($signed(x3_q[i]) > 8'sd0) ? x3_q[i] : 8'h00;
            Gelu:    out_d[i] = requant($signed(g3_q[i]), mult3_q, shift3_q, add3_q, mode3_q);
            default: out_d[i] = x3_q[i];
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x1_q     <= '0;
         act1_q   <= Identity;
         one1_q   <= '0;
         b1_q     <= '0;
         c1_q     <= '0;
         mode1_q  <= Signed;
         mult1_q  <= '0;
         shift1_q <= '0;
         add1_q   <= '0;
         x2_q     <= '0;
         act2_q   <= Identity;
         l2_q     <= '0;
         one2_q   <= '0;
         mode2_q  <= Signed;
         mult2_q  <= '0;
         shift2_q <= '0;
         add2_q   <= '0;
         x3_q     <= '0;
         act3_q   <= Identity;
         g3_q     <= '0;
         mode3_q  <= Signed;
         mult3_q  <= '0;
         shift3_q <= '0;
         add3_q   <= '0;
         data_o   <= '0;
      end else if (calc_en_q_i) begin
         x1_q     <= data_i;
         act1_q   <= activation_i;
         one1_q   <= one_i;
         b1_q     <= b_i;
         c1_q     <= c_i;
         mode1_q  <= requant_mode_i;
         mult1_q  <= requant_mult_i;
         shift1_q <= requant_shift_i;
         add1_q   <= requant_add_i;
         x2_q     <= x1_q;
         act2_q   <= act1_q;
         l2_q     <= l2_d;
         one2_q   <= one1_q;
         mode2_q  <= mode1_q;
         mult2_q  <= mult1_q;
         shift2_q <= shift1_q;
         add2_q   <= add1_q;
         x3_q     <= x2_q;
         act3_q   <= act2_q;
         g3_q     <= g3_d;
         mode3_q  <= mode2_q;
         mult3_q  <= mult2_q;
         shift3_q <= shift2_q;
         add3_q   <= add2_q;
         data_o   <= out_d;
      end
   end

`ifdef ACTIVATION_ASSERT_EN
   act_code_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      2'(activation_i) != 2'd3);
   shift_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      requant_shift_i <= 8'd31);
   data_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown(data_o));
`else
   // Checks disabled; datapath is unaffected.
`endif

endmodule

// File: tb/tb_activation.sv
// Directed self-checking bench for the activation pipeline: latency, modes, saturation, stall, reset.
module tb_activation;
   import ita_package::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   gelu_const_t    one, b, c;
   requant_oup_t   data_in;
   activation_e    act;
   requant_mode_e  mode;
   requant_const_t mult, shift;
   requant_t       add;
   logic           en;
   requant_oup_t   data_out;

   int checks = 0;
   int failures = 0;

   activation dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .one_i          (one),
      .b_i            (b),
      .c_i            (c),
      .data_i         (data_in),
      .activation_i   (act),
      .requant_mode_i (mode),
      .requant_mult_i (mult),
      .requant_shift_i(shift),
      .requant_add_i  (add),
      .calc_en_q_i    (en),
      .data_o         (data_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic requant_oup_t lanes5(input int l0, input int l1, input int l2,
                                           input int l3, input int l4, input int rest);
      requant_oup_t r;
      for (int i = 0; i < int'(N_PE); i++) r[i] = 8'(rest);
      r[0] = 8'(l0);
      r[1] = 8'(l1);
      r[2] = 8'(l2);
      r[3] = 8'(l3);
      r[4] = 8'(l4);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_gelu(input int o, input int sh, input int m, input int ad,
                           input requant_mode_e md);
      one   = 16'(o);
      b     = -16'sd8;
      c     = -16'sd64;
      shift = 8'(sh);
      mult  = 8'(m);
      add   = 8'(ad);
      mode  = md;
   endtask

   task automatic test_reset();
      set_gelu(10, 2, 1, 0, Signed);
      act = Gelu;
      data_in = lanes5(4, -4, 1, 2, 3, 9);
      en = 1'b1;
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (data_out !== '0) begin
         failures++;
         $display("FAIL reset_hold: data_o=%h expected=%h", data_out, requant_oup_t'('0));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      requant_oup_t e;
      e = lanes5(-128, -1, 0, 1, 2, 0);
      for (int i = 5; i < 15; i++) e[i] = 8'(i - 2);
      e[15] = 8'sd127;
      data_in = e;
      act = Identity;
      for (int s = 0; s < 4; s++) begin
         step();
         checks++;
         if (s < 3 && data_out !== '0) begin
            failures++;
            $display("FAIL identity_latency: data_o=%h expected=%h", data_out,
                     requant_oup_t'('0));
         end else if (s == 3 && data_out !== e) begin
            failures++;
            $display("FAIL identity: data_o=%h expected=%h", data_out, e);
         end
      end
   endtask

   task automatic test_relu();
      requant_oup_t prev, e;
      prev = data_out;
      e = lanes5(0, 7, 0, 127, 0, 0);
      data_in = lanes5(-5, 7, -128, 127, 0, 0);
      act = Relu;
      step();
      step();
      step();
      checks++;
      if (data_out !== prev) begin
         failures++;
         $display("FAIL relu_latency: data_o=%h expected=%h", data_out, prev);
      end
      step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL relu: data_o=%h expected=%h", data_out, e);
      end
   endtask

   task automatic test_gelu();
      requant_oup_t e;
      act = Gelu;
      set_gelu(10, 2, 1, 0, Signed);
      data_in = lanes5(4, -4, 0, 127, -128, 0);
      e = lanes5(-38, -58, 0, -128, -128, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL gelu_signed: data_o=%h expected=%h", data_out, e);
      end
      set_gelu(10, 2, 1, 100, Unsigned);
      e = lanes5(62, 42, 100, 0, 0, 100);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL gelu_unsigned_add: data_o=%h expected=%h", data_out, e);
      end
      // one=100 with shift=4 exercises rounding; mult=3 with negative add exercises scaling
      data_in = lanes5(4, -4, 1, 0, 0, 0);
      set_gelu(100, 4, 1, 0, Signed);
      e = lanes5(13, -37, 5, 0, 0, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL gelu_round: data_o=%h expected=%h", data_out, e);
      end
      set_gelu(100, 4, 3, -20, Signed);
      e = lanes5(19, -128, -4, -20, -20, -20);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL gelu_mult_add: data_o=%h expected=%h", data_out, e);
      end
   endtask

   task automatic test_saturation();
      requant_oup_t e;
      act = Gelu;
      data_in = lanes5(4, -4, 1, 0, 0, 0);
      set_gelu(10, 0, 1, 0, Signed);
      e = lanes5(-128, -128, -5, 0, 0, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL sat_signed_low: data_o=%h expected=%h", data_out, e);
      end
      set_gelu(10, 0, 1, 0, Unsigned);
      e = lanes5(0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL sat_unsigned_low: data_o=%h expected=%h", data_out, e);
      end
      set_gelu(100, 0, 1, 0, Signed);
      e = lanes5(127, -128, 85, 0, 0, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL sat_signed_high: data_o=%h expected=%h", data_out, e);
      end
      set_gelu(100, 0, 1, 0, Unsigned);
      e = lanes5(208, 0, 85, 0, 0, 0);
      for (int s = 0; s < 4; s++) step();
      checks++;
      if (data_out !== e) begin
         failures++;
         $display("FAIL sat_unsigned_high: data_o=%h expected=%h", data_out, e);
      end
   endtask

   task automatic test_mixed_stall();
      requant_oup_t b0, b1, b2, b3, b4;
      b0 = '0;
      for (int i = 0; i < int'(N_PE); i++) b0[i] = 8'(7 * i - 50);
      b4 = lanes5(17, 17, 17, 17, 17, 17);
      set_gelu(10, 2, 1, 0, Signed);
      en = 1'b1;
      data_in = b0;
      act = Identity;
      step();
      data_in = lanes5(-5, 7, -128, 127, 0, 0);
      act = Relu;
      step();
      data_in = lanes5(4, -4, 0, 0, 0, 0);
      act = Gelu;
      step();
      // Constants change after the Gelu beat was sampled; it must keep its own
      one  = 16'sd100;
      mult = 8'd3;
      data_in = lanes5(55, -66, 1, 0, 0, 0);
      act = activation_e'(2'd3);
      step();
      checks++;
      if (data_out !== b0) begin
         failures++;
         $display("FAIL mixed_b0: data_o=%h expected=%h", data_out, b0);
      end
      en = 1'b0;
      data_in = lanes5(99, 99, 99, 99, 99, 99);
      act = Gelu;
      for (int s = 0; s < 3; s++) begin
         step();
         checks++;
         if (data_out !== b0) begin
            failures++;
            $display("FAIL stall_hold: data_o=%h expected=%h", data_out, b0);
         end
      end
      en = 1'b1;
      data_in = b4;
      act = Identity;
      b1 = lanes5(0, 7, 0, 127, 0, 0);
      b2 = lanes5(-38, -58, 0, 0, 0, 0);
      b3 = lanes5(55, -66, 1, 0, 0, 0);
      step();
      checks++;
      if (data_out !== b1) begin
         failures++;
         $display("FAIL mixed_b1: data_o=%h expected=%h", data_out, b1);
      end
      step();
      checks++;
      if (data_out !== b2) begin
         failures++;
         $display("FAIL mixed_b2: data_o=%h expected=%h", data_out, b2);
      end
      step();
      checks++;
      if (data_out !== b3) begin
         failures++;
         $display("FAIL mixed_code3: data_o=%h expected=%h", data_out, b3);
      end
      step();
      checks++;
      if (data_out !== b4) begin
         failures++;
         $display("FAIL mixed_b4: data_o=%h expected=%h", data_out, b4);
      end
   endtask

   task automatic test_mid_reset();
      requant_oup_t n;
      n = lanes5(37, 37, 37, 37, 37, 37);
      act = Identity;
      data_in = lanes5(-9, 8, -7, 6, -5, 4);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (data_out !== '0) begin
         failures++;
         $display("FAIL reset_async: data_o=%h expected=%h", data_out, requant_oup_t'('0));
      end
      step();
      rst_n = 1'b1;
      data_in = n;
      for (int s = 0; s < 4; s++) begin
         step();
         checks++;
         if (s < 3 && data_out !== '0) begin
            failures++;
            $display("FAIL reset_flush: data_o=%h expected=%h", data_out, requant_oup_t'('0));
         end else if (s == 3 && data_out !== n) begin
            failures++;
            $display("FAIL reset_first_beat: data_o=%h expected=%h", data_out, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_relu();
      test_gelu();
      test_saturation();
      test_mixed_stall();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
